// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns unit.
// Accepts a 128-bit state on start, transforms COLS_PER_CYCLE columns per
// clock in a working register, then presents the result with a one-cycle
// done pulse.
//
// Handshake: start is sampled only while the FSM is in IDLE or DONE; an
// accepted start latches state_in on that edge. busy is high from the cycle
// after acceptance until the final group is written. done is high for
// exactly the one cycle in which state_out first shows the new result.
// start seen while busy is dropped, not queued.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done
);

    // Only whole divisions of the four columns are supported.
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Column counter step and the counter value of the final group.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FSM state is kept as a named signal so checkers can bind to it.
    state_t       state_q;
    state_t       state_d;
    logic [1:0]   cnt;
    logic [127:0] work;
    logic [127:0] work_next;
    logic         accept;
    logic         finish;

    // GF(2^8) multiply by 2 with reduction by 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns of one column: bytes a0..a3 from MSB down.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Working register with the current column group replaced by its transform.
    always_comb begin
        logic [31:0] cols [4];
        logic [1:0]  idx;
        work_next = '0;
        idx       = '0;
        for (int c = 0; c < 4; c++) begin
            cols[c] = work[127-32*c -: 32];
        end
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            idx       = cnt + 2'(g);
            cols[idx] = inv_col(cols[idx]);
        end
        for (int c = 0; c < 4; c++) begin
            work_next[127-32*c -: 32] = cols[c];
        end
    end

    // Next-state logic: accept in IDLE/DONE, finish on the last column group.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt       <= '0;
            work      <= '0;
            state_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= finish;
            if (accept) begin
                work <= state_in;
                cnt  <= '0;
                busy <= 1'b1;
            end else if (state_q == RUN) begin
                work <= work_next;
                cnt  <= cnt + STEP;
                if (finish) begin
                    state_out <= work_next;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Testbench for inv_mix_columns_seq: three instances (1, 2 and 4 columns
// per cycle) share one stimulus stream.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] state_in;
    logic [127:0] so1, so2, so4;
    logic         b1, b2, b4;
    logic         d1, d2, d4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic [127:0] vin;
        logic [127:0] vexp;
    } vec_t;

    vec_t vecs [6];

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
        .state_out(so1), .busy(b1), .done(d1));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
        .state_out(so2), .busy(b2), .done(d2));
    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
        .state_out(so4), .busy(b4), .done(d4));

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Forward MixColumns reference (encryption direction).
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block with a single-cycle start; checks latency, busy window,
    // single done pulse and result on all three instances.
    task automatic run_vec(input string name, input logic [127:0] vin, input logic [127:0] vexp);
        int fd1, fd2, fd4, nd1, nd2, nd4;
        fd1 = -1; fd2 = -1; fd4 = -1;
        nd1 = 0;  nd2 = 0;  nd4 = 0;
        state_in = vin;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        state_in = rand128();
        for (int cyc = 1; cyc <= 7; cyc++) begin
            check({name, "_busy1"}, 128'(b1), 128'(cyc <= 4));
            if (d1) begin nd1++; if (fd1 < 0) fd1 = cyc; end
            if (d2) begin nd2++; if (fd2 < 0) fd2 = cyc; end
            if (d4) begin nd4++; if (fd4 < 0) fd4 = cyc; end
            tick();
        end
        check_int({name, "_done_cyc1"}, fd1, 5);
        check_int({name, "_done_cyc2"}, fd2, 3);
        check_int({name, "_done_cyc4"}, fd4, 2);
        check_int({name, "_done_cnt1"}, nd1, 1);
        check_int({name, "_done_cnt2"}, nd2, 1);
        check_int({name, "_done_cnt4"}, nd4, 1);
        check({name, "_out1"}, so1, vexp);
        check({name, "_out2"}, so2, vexp);
        check({name, "_out4"}, so4, vexp);
    endtask

    initial begin
        logic [127:0] orig;
        logic [127:0] ra;
        logic [127:0] rb;
        bit           seen;

        vecs[0] = '{"col0",  128'h8e4da1bc_00000000_00000000_00000000,
                             128'hdb135345_00000000_00000000_00000000};
        vecs[1] = '{"full",  128'h9fdc589d_d5d5d7d6_01010101_c6c6c6c6,
                             128'hf20a225c_d4d4d4d5_01010101_c6c6c6c6};
        vecs[2] = '{"zero",  128'h0, 128'h0};
        vecs[3] = '{"ones",  {128{1'b1}}, {128{1'b1}}};
        vecs[4] = '{"col1",  128'h00000000_8e4da1bc_00000000_00000000,
                             128'h00000000_db135345_00000000_00000000};
        vecs[5] = '{"col3",  128'h01010101_00000000_c6c6c6c6_9fdc589d,
                             128'h01010101_00000000_c6c6c6c6_f20a225c};

        // Reset.
        rst_n    = 1'b0;
        start    = 1'b0;
        state_in = '0;
        tick();
        tick();
        check("rst_out1", so1, 128'h0);
        check("rst_busy1", 128'(b1), 128'h0);
        check("rst_done1", 128'(d1), 128'h0);
        check("rst_out4", so4, 128'h0);
        rst_n = 1'b1;
        tick();

        // Directed vectors.
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i].name, vecs[i].vin, vecs[i].vexp);
        end

        // Start held high: blocks accepted each DONE, RUN-time starts ignored.
        ra = vecs[0].vin;
        rb = vecs[1].vin;
        state_in = ra;
        start    = 1'b1;
        tick();
        state_in = rb;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            check($sformatf("b2b_done1_c%0d", cyc), 128'(d1), 128'(cyc == 5 || cyc == 10));
            if (cyc == 5)  check("b2b_out_a", so1, vecs[0].vexp);
            if (cyc == 10) check("b2b_out_b", so1, vecs[1].vexp);
            tick();
        end
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        // Reset in the second RUN cycle discards the block.
        state_in = vecs[4].vin;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        tick();
        rst_n    = 1'b0;
        tick();
        check("mrst_busy1", 128'(b1), 128'h0);
        check("mrst_done1", 128'(d1), 128'h0);
        check("mrst_out1", so1, 128'h0);
        check("mrst_out2", so2, 128'h0);
        check("mrst_out4", so4, 128'h0);
        rst_n = 1'b1;
        tick();
        run_vec("after_rst", vecs[1].vin, vecs[1].vexp);

        // Round trip through forward MixColumns.
        for (int n = 0; n < 1000; n++) begin
            orig     = rand128();
            state_in = mix_state(orig);
            start    = 1'b1;
            tick();
            start    = 1'b0;
            seen     = 1'b0;
            for (int w = 0; w < 10 && !seen; w++) begin
                if (d1) seen = 1'b1;
                else tick();
            end
            check_int("rt_done_seen", int'(seen), 1);
            check("rt_out1", so1, orig);
            check("rt_out2", so2, orig);
            check("rt_out4", so4, orig);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Sequential AES InvMixColumns unit for the decryption datapath. It is the inverse counterpart of the encryption MixColumns xtime lookup path.
- Accepts a 128-bit state on a start pulse.
- Transforms COLS_PER_CYCLE columns per clock, writing results back into a working register.
- Presents the result with a one-cycle done pulse.
- Sits between InvShiftRows/InvSubBytes/AddRoundKey stages in the round controller.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per RUN cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request: sample state_in and begin transform
state_in  input  128  input state; [127:120]=byte0, FIPS-197 column-major, column c = bytes 4c..4c+3
state_out  output  128  result register, same byte order; holds last result until overwritten
busy  output  1  high while transform in progress
done  output  1  one-cycle pulse: state_out newly valid

Behaviour:
- Reset (rst_n=0 at an edge): FSM=IDLE, col counter=0, working reg=0, state_out=0, busy=0, done=0. Reset mid-RUN discards the in-flight state; there is no partial write to state_out.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches state_in into the working reg and clears the col counter.
  - Next state is RUN; busy=1 from the next cycle.
  - start=0 stays IDLE.
- RUN:
  - Each edge replaces columns [cnt .. cnt+COLS_PER_CYCLE-1] of the working reg with their InvMixColumns value.
  - cnt advances by COLS_PER_CYCLE.
  - On the edge processing the final group:
    - state_out <= full updated state, including the columns computed that edge;
    - done <= 1, busy <= 0, next state DONE.
  - start during RUN is ignored; it is not queued.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 here is accepted exactly as in IDLE, giving back-to-back operation.
  - Otherwise next state is IDLE.
- Latency: start high in cycle 0 gives done high in cycle 1+4/COLS_PER_CYCLE (COLS=1: cycle 5; COLS=4: cycle 2). Throughput is one block per 1+4/COLS cycles.
- Column math, input a0..a3, output b0..b3, all GF(2^8) with poly 0x11B:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - b2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - b3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplies are built from an xtime chain: x2, x4 = x2(x2), x8 = x2(x4), then 09 = x8^a, 0b = x8^x2^a, 0d = x8^x4^a, 0e = x8^x4^x2.
- xtime: shift left 1, XOR 0x1B if bit7 was set; the result is always 8 bits.
- The block is fully combinational per column inside the one register stage; there are no X outputs for any input byte.
- state_in is sampled only on the accepting edge; later changes have no effect.

Test Plan:
- Single column, COLS=1: state_in column 0 = 8e 4d a1 bc, others 00; start one cycle -> done in cycle 5, state_out column 0 = db 13 53 45, other columns 00, busy high cycles 1-4.
- Full state: columns {9f dc 58 9d, d5 d5 d7 d6, 01 01 01 01, c6 c6 c6 c6} -> {f2 0a 22 5c, d4 d4 d4 d5, 01 01 01 01, c6 c6 c6 c6}; repeat with COLS=2 (done cycle 3) and COLS=4 (done cycle 2).
- Round trip: random 1000 states run through the encryption MixColumns reference model, then this block -> output equals original state every time; also all-ff and all-00 states give no X.
- Start held high continuously -> a new block is accepted each DONE cycle; done pulses every 5 cycles (COLS=1); start pulses during RUN are ignored and state_out equals the first block's result.
- rst_n low in cycle 2 of RUN -> next cycle busy=0, done=0, state_out=0, FSM IDLE; a later start completes normally with correct result.
